// File: rtl/fifo_ring_wr_arbiter.sv
// Round-robin burst write arbiter that shares one fifo_ring write port between NUM_REQ requesters.
// Optional per-requester beat and stall statistics are enabled by FIFO_RING_WR_ARBITER_STATS_EN.
module fifo_ring_wr_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 1024,
  parameter int unsigned MAX_BURST  = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              i_req_valid,
  input  logic [NUM_REQ-1:0]              i_req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   i_req_data,
  output logic [NUM_REQ-1:0]              o_req_ready,
  input  logic [$clog2(FIFO_DEPTH):0]     i_fifo_fill_count,
  output logic                            o_fifo_wr_valid,
  output logic [DATA_WIDTH-1:0]           o_fifo_wr_data,
  output logic [NUM_REQ-1:0]              o_grant,
  output logic                            o_busy
`ifdef FIFO_RING_WR_ARBITER_STATS_EN
  ,
  output logic [NUM_REQ*32-1:0]           o_beat_count,
  output logic [31:0]                     o_stall_cycles
`endif
);

  localparam int unsigned FILL_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned SPACE_W = FILL_W + 1;
  localparam int unsigned IDX_W   = $clog2(NUM_REQ);
  localparam int unsigned CNT_W   = $clog2(MAX_BURST) + 1;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  logic [0:0]            state, state_nxt;
  logic [NUM_REQ-1:0]    grant_nxt;
  logic [IDX_W-1:0]      gidx, gidx_nxt;
  logic [IDX_W-1:0]      rr, rr_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic                  wr_valid_nxt;
  logic [DATA_WIDTH-1:0] wr_data_nxt;

  logic [DATA_WIDTH-1:0] req_data [NUM_REQ];
  logic [SPACE_W-1:0]    space_sum;
  logic                  space_ok;
  logic                  accept;
  logic                  found;
  logic [IDX_W-1:0]      pick;
  logic [IDX_W-1:0]      cand;

  for (genvar k = 0; k < int'(NUM_REQ); k++) begin : g_unpack
    assign req_data[k] = i_req_data[k*DATA_WIDTH +: DATA_WIDTH];
  end

  // A registered beat not yet reflected in the fill count still occupies a slot.
  assign space_sum = SPACE_W'(i_fifo_fill_count) + SPACE_W'(o_fifo_wr_valid);
  assign space_ok  = space_sum < SPACE_W'(FIFO_DEPTH);
  assign accept    = (state == GRANT) && i_req_valid[gidx] && space_ok;
  assign o_busy    = (state == GRANT);

  always_comb begin
    o_req_ready = '0;
    if (state == GRANT) o_req_ready[gidx] = space_ok;
  end

  // Round-robin search starting one past the last released requester.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int i = 1; i <= int'(NUM_REQ); i++) begin
      cand = IDX_W'((int'(rr) + i) % int'(NUM_REQ));
      if (!found && i_req_valid[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      o_grant         <= '0;
      gidx            <= '0;
      rr              <= IDX_W'(NUM_REQ - 1);
      cnt             <= '0;
      o_fifo_wr_valid <= 1'b0;
      o_fifo_wr_data  <= '0;
    end else begin
      state           <= state_nxt;
      o_grant         <= grant_nxt;
      gidx            <= gidx_nxt;
      rr              <= rr_nxt;
      cnt             <= cnt_nxt;
      o_fifo_wr_valid <= wr_valid_nxt;
      o_fifo_wr_data  <= wr_data_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    grant_nxt    = o_grant;
    gidx_nxt     = gidx;
    rr_nxt       = rr;
    cnt_nxt      = cnt;
    wr_valid_nxt = 1'b0;
    wr_data_nxt  = o_fifo_wr_data;
    case (state)
      IDLE: begin
        if (found) begin
          grant_nxt = NUM_REQ'(1) << pick;
          gidx_nxt  = pick;
          cnt_nxt   = '0;
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        if (accept) begin
          wr_valid_nxt = 1'b1;
          wr_data_nxt  = req_data[gidx];
          cnt_nxt      = cnt + CNT_W'(1);
          // Bursts end on the last beat or are cut at MAX_BURST to bound latency for others.
          if (i_req_last[gidx] || (cnt_nxt == CNT_W'(MAX_BURST))) begin
            rr_nxt    = gidx;
            grant_nxt = '0;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef FIFO_RING_WR_ARBITER_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      o_beat_count   <= '0;
      o_stall_cycles <= '0;
    end else begin
      if (accept) o_beat_count[gidx*32 +: 32] <= o_beat_count[gidx*32 +: 32] + 32'd1;
      if ((state == GRANT) && i_req_valid[gidx] && !space_ok) o_stall_cycles <= o_stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_ring_wr_arbiter.sv
// Directed bench for fifo_ring_wr_arbiter: per-scenario tasks with hand-computed expectations.
module tb_fifo_ring_wr_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  i_req_valid;
  logic [3:0]  i_req_last;
  logic [127:0] i_req_data;
  logic [3:0]  o_req_ready;
  logic [10:0] i_fifo_fill_count;
  logic        o_fifo_wr_valid;
  logic [31:0] o_fifo_wr_data;
  logic [3:0]  o_grant;
  logic        o_busy;

  int checks = 0;
  int errors = 0;

  logic [32:0] sq [4][$];
  bit   [3:0]  en;
  logic [31:0] wr_q [$];
  logic [3:0]  gnt_q [$];
  logic [3:0]  prev_grant;
  int          b2b;

  fifo_ring_wr_arbiter dut (
    .clk               (clk),
    .rst               (rst),
    .i_req_valid       (i_req_valid),
    .i_req_last        (i_req_last),
    .i_req_data        (i_req_data),
    .o_req_ready       (o_req_ready),
    .i_fifo_fill_count (i_fifo_fill_count),
    .o_fifo_wr_valid   (o_fifo_wr_valid),
    .o_fifo_wr_data    (o_fifo_wr_data),
    .o_grant           (o_grant),
    .o_busy            (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive();
    for (int k = 0; k < 4; k++) begin
      i_req_valid[k] = en[k] && (sq[k].size() > 0);
      i_req_last[k]  = (sq[k].size() > 0) ? sq[k][0][32] : 1'b0;
      i_req_data[k*32 +: 32] = (sq[k].size() > 0) ? sq[k][0][31:0] : 32'h0;
    end
  endtask

  // One clock: observe at negedge, consume accepted beats and re-drive after posedge.
  task automatic tick();
    logic [3:0] fired;
    @(negedge clk);
    fired = i_req_valid & o_req_ready;
    if (o_fifo_wr_valid) wr_q.push_back(o_fifo_wr_data);
    if (o_grant != 4'b0 && prev_grant == 4'b0) gnt_q.push_back(o_grant);
    if (o_grant != 4'b0 && prev_grant != 4'b0 && o_grant != prev_grant) b2b++;
    prev_grant = o_grant;
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) if (fired[k]) void'(sq[k].pop_front());
    drive();
    #1;
  endtask

  task automatic push(input int k, input logic [31:0] d, input bit last);
    sq[k].push_back({last, d});
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    for (int k = 0; k < 4; k++) sq[k].delete();
    en = 4'hF;
    i_fifo_fill_count = 11'd0;
    drive();
    tick();
    tick();
    rst = 1'b0;
    wr_q.delete();
    gnt_q.delete();
    prev_grant = 4'b0;
    b2b = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en = 4'hF;
    i_fifo_fill_count = 11'd0;
    drive();
    tick();
    tick();
    checks++; if (o_grant !== 4'b0) begin errors++; $display("FAIL reset_grant: got %h want 0", o_grant); end
    checks++; if (o_req_ready !== 4'b0) begin errors++; $display("FAIL reset_ready: got %h want 0", o_req_ready); end
    checks++; if (o_fifo_wr_valid !== 1'b0) begin errors++; $display("FAIL reset_wr_valid: got %b want 0", o_fifo_wr_valid); end
    checks++; if (o_fifo_wr_data !== 32'h0) begin errors++; $display("FAIL reset_wr_data: got %h want 0", o_fifo_wr_data); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", o_busy); end
    rst = 1'b0;
  endtask

  task automatic test_single();
    logic [31:0] exp_d [3];
    exp_d[0] = 32'hA0; exp_d[1] = 32'hA1; exp_d[2] = 32'hA2;
    apply_reset();
    push(0, 32'hA0, 1'b0); push(0, 32'hA1, 1'b0); push(0, 32'hA2, 1'b1);
    drive(); #1;
    tick();
    checks++; if (o_grant !== 4'b0001) begin errors++; $display("FAIL single_grant: got %h want 1", o_grant); end
    checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", o_busy); end
    checks++; if (o_fifo_wr_valid !== 1'b0) begin errors++; $display("FAIL single_no_write_idle: got %b want 0", o_fifo_wr_valid); end
    for (int j = 0; j < 3; j++) begin
      tick();
      checks++;
      if (o_fifo_wr_valid !== 1'b1 || o_fifo_wr_data !== exp_d[j]) begin
        errors++; $display("FAIL single_beat%0d: got v=%b d=%h want v=1 d=%h", j, o_fifo_wr_valid, o_fifo_wr_data, exp_d[j]);
      end
    end
    checks++; if (o_grant !== 4'b0) begin errors++; $display("FAIL single_release: got %h want 0", o_grant); end
    tick();
    checks++; if (o_fifo_wr_valid !== 1'b0) begin errors++; $display("FAIL single_idle_valid: got %b want 0", o_fifo_wr_valid); end
    checks++; if (o_fifo_wr_data !== 32'hA2) begin errors++; $display("FAIL single_data_hold: got %h want a2", o_fifo_wr_data); end
  endtask

  task automatic test_round_robin();
    logic [3:0]  exp_g [8];
    logic [31:0] exp_d [8];
    apply_reset();
    for (int j = 0; j < 2; j++)
      for (int k = 0; k < 4; k++) push(k, 32'h1000 * (k + 1) + j, 1'b1);
    for (int n = 0; n < 8; n++) begin
      exp_g[n] = 4'b0001 << (n % 4);
      exp_d[n] = 32'h1000 * ((n % 4) + 1) + (n / 4);
    end
    drive(); #1;
    for (int t = 0; t < 20; t++) tick();
    checks++; if (gnt_q.size() != 8) begin errors++; $display("FAIL rr_grant_count: got %0d want 8", gnt_q.size()); end
    checks++; if (wr_q.size() != 8) begin errors++; $display("FAIL rr_write_count: got %0d want 8", wr_q.size()); end
    for (int n = 0; n < 8; n++) begin
      if (n < gnt_q.size()) begin
        checks++; if (gnt_q[n] !== exp_g[n]) begin errors++; $display("FAIL rr_grant%0d: got %h want %h", n, gnt_q[n], exp_g[n]); end
      end
      if (n < wr_q.size()) begin
        checks++; if (wr_q[n] !== exp_d[n]) begin errors++; $display("FAIL rr_data%0d: got %h want %h", n, wr_q[n], exp_d[n]); end
      end
    end
    checks++; if (b2b != 0) begin errors++; $display("FAIL rr_idle_gap: got %0d back-to-back grants want 0", b2b); end
  endtask

  task automatic test_forced_release();
    logic [31:0] exp_d [$];
    logic [3:0]  exp_g [4];
    int t;
    apply_reset();
    en = 4'b0100;
    for (int j = 0; j < 40; j++) push(2, 32'h2000 + j, 1'b0);
    push(1, 32'h1000, 1'b0); push(1, 32'h1001, 1'b1);
    drive(); #1;
    tick();
    en = 4'b0110;
    drive(); #1;
    t = 0;
    while ((sq[1].size() > 0 || sq[2].size() > 0) && t < 150) begin tick(); t++; end
    checks++; if (t >= 150) begin errors++; $display("FAIL forced_timeout: got %0d cycles want <150", t); end
    for (int j = 0; j < 3; j++) tick();
    for (int j = 0; j < 16; j++) exp_d.push_back(32'h2000 + j);
    exp_d.push_back(32'h1000); exp_d.push_back(32'h1001);
    for (int j = 16; j < 40; j++) exp_d.push_back(32'h2000 + j);
    exp_g[0] = 4'b0100; exp_g[1] = 4'b0010; exp_g[2] = 4'b0100; exp_g[3] = 4'b0100;
    checks++; if (wr_q.size() != 42) begin errors++; $display("FAIL forced_write_count: got %0d want 42", wr_q.size()); end
    checks++; if (gnt_q.size() != 4) begin errors++; $display("FAIL forced_grant_count: got %0d want 4", gnt_q.size()); end
    for (int n = 0; n < 42 && n < wr_q.size(); n++) begin
      checks++; if (wr_q[n] !== exp_d[n]) begin errors++; $display("FAIL forced_data%0d: got %h want %h", n, wr_q[n], exp_d[n]); end
    end
    for (int n = 0; n < 4 && n < gnt_q.size(); n++) begin
      checks++; if (gnt_q[n] !== exp_g[n]) begin errors++; $display("FAIL forced_grant%0d: got %h want %h", n, gnt_q[n], exp_g[n]); end
    end
  endtask

  task automatic test_full_guard();
    int t;
    apply_reset();
    i_fifo_fill_count = 11'd1022;
    for (int j = 0; j < 10; j++) push(0, 32'h3000 + j, j == 9);
    drive(); #1;
    tick();
    checks++; if (o_req_ready !== 4'b0001) begin errors++; $display("FAIL full_ready_1022: got %h want 1", o_req_ready); end
    tick();
    i_fifo_fill_count = 11'd1023; #1;
    checks++; if (o_fifo_wr_valid !== 1'b1 || o_fifo_wr_data !== 32'h3000) begin errors++; $display("FAIL full_first_write: got v=%b d=%h want v=1 d=3000", o_fifo_wr_valid, o_fifo_wr_data); end
    checks++; if (o_req_ready !== 4'b0) begin errors++; $display("FAIL full_ready_inflight: got %h want 0", o_req_ready); end
    tick();
    checks++; if (o_fifo_wr_valid !== 1'b0) begin errors++; $display("FAIL full_no_write: got %b want 0", o_fifo_wr_valid); end
    checks++; if (o_req_ready !== 4'b0001) begin errors++; $display("FAIL full_ready_1023_idle: got %h want 1", o_req_ready); end
    tick();
    i_fifo_fill_count = 11'd1024; #1;
    checks++; if (o_fifo_wr_valid !== 1'b1 || o_fifo_wr_data !== 32'h3001) begin errors++; $display("FAIL full_second_write: got v=%b d=%h want v=1 d=3001", o_fifo_wr_valid, o_fifo_wr_data); end
    checks++; if (o_req_ready !== 4'b0) begin errors++; $display("FAIL full_ready_1024: got %h want 0", o_req_ready); end
    for (int j = 0; j < 2; j++) begin
      tick();
      checks++; if (o_fifo_wr_valid !== 1'b0 || o_req_ready !== 4'b0) begin errors++; $display("FAIL full_stall%0d: got v=%b r=%h want v=0 r=0", j, o_fifo_wr_valid, o_req_ready); end
    end
    checks++; if (o_grant !== 4'b0001) begin errors++; $display("FAIL full_grant_held: got %h want 1", o_grant); end
    i_fifo_fill_count = 11'd1022; #1;
    checks++; if (o_req_ready !== 4'b0001) begin errors++; $display("FAIL full_resume_ready: got %h want 1", o_req_ready); end
    tick();
    checks++; if (o_fifo_wr_valid !== 1'b1 || o_fifo_wr_data !== 32'h3002) begin errors++; $display("FAIL full_resume_write: got v=%b d=%h want v=1 d=3002", o_fifo_wr_valid, o_fifo_wr_data); end
    i_fifo_fill_count = 11'd0;
    t = 0;
    while (sq[0].size() > 0 && t < 40) begin tick(); t++; end
    checks++; if (t >= 40) begin errors++; $display("FAIL full_drain_timeout: got %0d cycles want <40", t); end
    tick(); tick();
    checks++; if (wr_q.size() != 10) begin errors++; $display("FAIL full_write_count: got %0d want 10", wr_q.size()); end
    for (int n = 0; n < 10 && n < wr_q.size(); n++) begin
      checks++; if (wr_q[n] !== 32'h3000 + n) begin errors++; $display("FAIL full_data%0d: got %h want %h", n, wr_q[n], 32'h3000 + n); end
    end
  endtask

  task automatic test_valid_gap();
    logic [31:0] exp_d [4];
    int t;
    apply_reset();
    push(0, 32'h4000, 1'b0); push(0, 32'h4001, 1'b0); push(0, 32'h4002, 1'b1);
    push(3, 32'h4300, 1'b1);
    drive(); #1;
    t = 0;
    while (sq[0].size() != 1 && t < 10) begin tick(); t++; end
    checks++; if (t >= 10) begin errors++; $display("FAIL gap_timeout: got %0d cycles want <10", t); end
    en[0] = 1'b0;
    drive(); #1;
    for (int j = 0; j < 5; j++) begin
      tick();
      checks++; if (o_grant !== 4'b0001) begin errors++; $display("FAIL gap_hold%0d: got %h want 1", j, o_grant); end
    end
    en[0] = 1'b1;
    drive(); #1;
    for (int j = 0; j < 8; j++) tick();
    exp_d[0] = 32'h4000; exp_d[1] = 32'h4001; exp_d[2] = 32'h4002; exp_d[3] = 32'h4300;
    checks++; if (gnt_q.size() != 2) begin errors++; $display("FAIL gap_grant_count: got %0d want 2", gnt_q.size()); end
    if (gnt_q.size() == 2) begin
      checks++; if (gnt_q[0] !== 4'b0001 || gnt_q[1] !== 4'b1000) begin errors++; $display("FAIL gap_grant_order: got %h,%h want 1,8", gnt_q[0], gnt_q[1]); end
    end
    checks++; if (wr_q.size() != 4) begin errors++; $display("FAIL gap_write_count: got %0d want 4", wr_q.size()); end
    for (int n = 0; n < 4 && n < wr_q.size(); n++) begin
      checks++; if (wr_q[n] !== exp_d[n]) begin errors++; $display("FAIL gap_data%0d: got %h want %h", n, wr_q[n], exp_d[n]); end
    end
  endtask

  task automatic test_reset_mid();
    int t;
    apply_reset();
    for (int j = 0; j < 6; j++) push(1, 32'h6100 + j, 1'b0);
    drive(); #1;
    t = 0;
    while (sq[1].size() != 3 && t < 10) begin tick(); t++; end
    checks++; if (t >= 10) begin errors++; $display("FAIL rstmid_timeout: got %0d cycles want <10", t); end
    checks++; if (o_grant !== 4'b0010) begin errors++; $display("FAIL rstmid_pre_grant: got %h want 2", o_grant); end
    rst = 1'b1;
    tick();
    checks++; if (o_grant !== 4'b0) begin errors++; $display("FAIL rstmid_grant: got %h want 0", o_grant); end
    checks++; if (o_fifo_wr_valid !== 1'b0) begin errors++; $display("FAIL rstmid_wr_valid: got %b want 0", o_fifo_wr_valid); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", o_busy); end
    rst = 1'b0;
    push(0, 32'h6000, 1'b1);
    drive(); #1;
    tick();
    checks++; if (o_grant !== 4'b0001) begin errors++; $display("FAIL rstmid_priority: got %h want 1", o_grant); end
  endtask

  initial begin
    rst = 1'b1;
    en = 4'hF;
    i_req_valid = '0;
    i_req_last = '0;
    i_req_data = '0;
    i_fifo_fill_count = '0;
    prev_grant = '0;
    b2b = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_forced_release();
    test_full_guard();
    test_valid_gap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_ring_wr_arbiter.md
Name: fifo_ring_wr_arbiter

Overview:
- Round-robin write arbiter that shares one fifo_ring write port between NUM_REQ requesters.
- Grants whole bursts: a grant is held until the requester's last beat or until MAX_BURST beats.
- Gates every write on FIFO space, since fifo_ring does not block writes when full.
- Sits between the acquisition/packetiser sources and the shared event FIFO.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- DATA_WIDTH, 32, beat width; equals the FIFO RAM_WIDTH.
- FIFO_DEPTH, 1024, depth of the attached FIFO; equals its RAM_DEPTH.
- MAX_BURST, 16, maximum beats per grant before forced release (>=1).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- i_req_valid  in  NUM_REQ  per-requester beat valid.
- i_req_last  in  NUM_REQ  per-requester last beat of burst.
- i_req_data  in  NUM_REQ*DATA_WIDTH  requester k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- o_req_ready  out  NUM_REQ  per-requester beat accept.
- i_fifo_fill_count  in  $clog2(FIFO_DEPTH)+1  FIFO o_fill_count.
- o_fifo_wr_valid  out  1  to FIFO i_wr_valid.
- o_fifo_wr_data  out  DATA_WIDTH  to FIFO i_wr_data.
- o_grant  out  NUM_REQ  one-hot current grant; all zero when idle.
- o_busy  out  1  high in GRANT state.

Behaviour:
- Single clock domain (clk). Reset is synchronous and active-high (rst).
- Reset values:
  - state = IDLE; o_grant = 0; o_req_ready = 0.
  - o_fifo_wr_valid = 0; o_fifo_wr_data = 0; o_busy = 0.
  - beat counter = 0; rr pointer = NUM_REQ-1, so requester 0 has first priority.
  - Reset mid-burst abandons the burst immediately. Any in-flight beat is dropped and o_fifo_wr_valid is 0 the next cycle.
- space_ok (combinational) = (i_fifo_fill_count + o_fifo_wr_valid) < FIFO_DEPTH.
  - Compute in $clog2(FIFO_DEPTH)+2 bits.
  - This accounts for a beat registered but not yet counted by the FIFO.
  - Conservative: FIFO reads are ignored.
- State IDLE:
  - Searches i_req_valid starting at index rr+1, wrapping modulo NUM_REQ.
  - If any valid: registers the one-hot grant, clears the beat counter, goes to GRANT next cycle.
  - No beat is accepted in IDLE.
- State GRANT (granted index g):
  - o_req_ready[g] = space_ok; all other ready bits are 0.
  - Beat accepted when i_req_valid[g] & o_req_ready[g].
  - If g deasserts valid mid-burst, the grant is kept (bursts are atomic); the arbiter waits.
- Release condition: an accepted beat with i_req_last[g]=1, or the accepted beat that makes the beat counter reach MAX_BURST.
  - On release: rr <= g, o_grant <= 0, state <= IDLE.
  - Minimum one idle cycle between grants.
- Write latency:
  - Accepted beat appears on o_fifo_wr_valid/o_fifo_wr_data exactly 1 cycle later (registered).
  - o_fifo_wr_valid = 0 on any cycle following no accept.
  - o_fifo_wr_data holds its last value when not valid.
- Throughput: 1 beat/cycle within a burst while space_ok.
- Full boundary: at fill_count = FIFO_DEPTH-1 with a beat in flight, space_ok = 0. No write is ever issued into a full FIFO.
- Beat counter is $clog2(MAX_BURST)+1 bits wide, saturates never (release resets it).

Optional Feature:
- Macro: FIFO_RING_WR_ARBITER_STATS_EN.
- When defined:
  - Adds output o_beat_count (NUM_REQ*32). Requester k's 32-bit counter is incremented on each accepted beat, wraps at 2^32, and clears on rst.
  - Adds output o_stall_cycles (32), incremented each GRANT cycle with i_req_valid[g]=1 and space_ok=0.
- When undefined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Single requester: rst, then req0 sends 3 beats (0xA0,0xA1,0xA2, last on third), fill=0 -> grant0 one cycle after valid; wr_valid high 3 consecutive cycles with data 0xA0..0xA2, each one cycle after accept; o_grant=0 after the last beat.
- Round-robin: all 4 valid continuously with 1-beat bursts (last=1) -> grant order 0,1,2,3,0,1 with one idle cycle between grants.
- Forced release (MAX_BURST=16): req2 streams 40 beats, never last; req1 also valid -> req2 released after beat 16, req1 granted next, req2 regranted later; no beat lost or duplicated.
- Full guard: fill_count driven 1022 then 1023, req0 streaming -> exactly one beat written at 1022, ready=0 while fill+in-flight>=1024; writing resumes the cycle after fill drops to 1022.
- Valid gap mid-burst: req0 valid for 2 beats, low 5 cycles, then last beat; req3 waiting -> grant stays on req0 throughout; req3 granted only after req0's last beat.
- Reset mid-burst: rst asserted during req1's 4th beat -> next cycle o_grant=0, o_fifo_wr_valid=0; after release, requester 0 has priority.
